decode_pkt_buffer: RTL and testbench
====================================

# decode_pkt_buffer

Parametrised, compacting in-order buffer between the decode stage and rename. Each cycle it accepts up to IN_WIDTH decoded packets, some of which may be holes left by uncracked (single-part) instructions. It squeezes out the invalid lanes, stores the valid packets in program order, and presents up to OUT_WIDTH packets per cycle to rename with a ready handshake. It decouples the fetch/decode width from the rename width and absorbs rename stalls.

## Interface
Parameters:
- IN_WIDTH, 8, input lanes (2× fetch width, one per split-packet slot).
- OUT_WIDTH, 4, output lanes to rename.
- DEPTH, 32, storage entries; power of two, ≥ IN_WIDTH+OUT_WIDTH.
- PKT_BITS, 64, flattened packet width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- flush_i  input  1  discard all contents (mispredict/exception recovery).
- inValid_i  input  IN_WIDTH  per-lane valid; holes allowed anywhere.
- inPkt_i  input  IN_WIDTH*PKT_BITS  lane k at bits [k*PKT_BITS +: PKT_BITS].
- decodeReady_o  output  1  free entries ≥ IN_WIDTH; upstream may present a group.
- outValid_o  output  OUT_WIDTH  per-lane valid, always contiguous from lane 0.
- outPkt_o  output  OUT_WIDTH*PKT_BITS  oldest packets, lane 0 oldest.
- renameReady_i  input  1  rename consumes all asserted outValid_o lanes this cycle.
- count_o  output  $clog2(DEPTH+1)  occupied entries.
- outLaneActive_i  input  OUT_WIDTH  present only with DECBUF_LANE_GATE_EN.

## Operation
- State: storage[DEPTH], head, tail (log2 DEPTH bits, wrap naturally), count.
- Write:
  - Occurs when decodeReady_o=1. nIn = popcount(inValid_i).
  - The valid lanes, taken in ascending lane order, go to storage[tail], storage[tail+1], … (mod DEPTH).
  - tail += nIn.
  - When decodeReady_o=0, inputs are ignored; upstream must hold them.
- Read:
  - avail = min(count, laneLimit); laneLimit = OUT_WIDTH (or the gated value, see Configuration).
  - outValid_o[k] = (k < avail); outPkt_o lane k = storage[head+k].
  - When renameReady_i=1, nOut = avail and head += nOut; otherwise nOut = 0.
  - Dispatch is all-or-nothing per cycle.
- count_next = count + nIn − nOut. Simultaneous read and write is always legal.
- decodeReady_o = (DEPTH − count) ≥ IN_WIDTH, computed from registered count. It does not credit same-cycle reads (conservative).
- flush_i:
  - Next cycle head = tail = count = 0.
  - Overrides any same-cycle write and read.
  - Storage data is not cleared.
- reset: same effect as flush. Priority is reset > flush > normal.
- Invalid lanes' inPkt_i are don't-care and are never stored.
- Overflow is impossible by construction. A count exceeding DEPTH is an assertion failure.

## Timing
- Reset values:
  - outValid_o = 0; count_o = 0; decodeReady_o = 1.
  - outPkt_o is don't-care (storage is not reset).
- Write-to-output latency is 1 cycle. A packet written in cycle N is visible on outPkt_o in cycle N+1 at the earliest. There is no bypass.
- Outputs are functions of registered state (plus outLaneActive_i when gated). There is no combinational path from inValid_i/inPkt_i to any output.
- renameReady_i affects only next-state, never same-cycle outputs.
- Wrap-around: head/tail wrap from DEPTH−1 to 0. Order is preserved across the boundary for both writes and the output window.
- Full/empty boundaries:
  - Empty: outValid_o = 0, and renameReady_i has no effect.
  - Count = DEPTH−IN_WIDTH: decodeReady_o = 1.
  - Count = DEPTH−IN_WIDTH+1: decodeReady_o = 0.

## Configuration
- DECBUF_LANE_GATE_EN defined:
  - The outLaneActive_i port exists.
  - laneLimit = popcount(outLaneActive_i). Active lanes must be contiguous from lane 0, and lane 0 must always be active.
  - Inactive lanes drive outValid_o = 0.
  - outLaneActive_i may change any cycle; it takes effect in the same cycle.
- DECBUF_LANE_GATE_EN undefined: no port; laneLimit = OUT_WIDTH.

## Test plan
- Reset held 2 cycles then released → count_o=0, outValid_o=0, decodeReady_o=1.
- Default parameters, count=0, renameReady_i=0, inValid_i=8'b1010_0101 with each packet = its lane index → next cycle count_o=4, outValid_o=4'b1111, outPkt lanes 0..3 = 0,2,5,7.
- Full boundary and wrap-around:
  - Fill to count=24 → decodeReady_o=1.
  - Write one more packet (count 25) → decodeReady_o=0.
  - Drain and refill so head/tail cross entry 31→0 → output sequence remains strictly in program order.
- Simultaneous events:
  - count=6, write 8 valid lanes, renameReady_i=1 → 4 dispatched, count_o=10 next cycle.
  - count=2, renameReady_i=1 → outValid_o=4'b0011, count_o=0 next cycle.
- flush_i asserted in the same cycle as an 8-lane write and renameReady_i=1 with count=12 → next cycle count_o=0, outValid_o=0, decodeReady_o=1. Fresh writes afterwards appear in order starting at lane 0.
- With DECBUF_LANE_GATE_EN, outLaneActive_i=4'b0011, count=6, renameReady_i=1 → outValid_o=4'b0011, 2 dispatched, count_o=4.

Source files
------------

// File: rtl/decode_pkt_buffer_if.sv
// rtl/decode_pkt_buffer_if.sv - decode-to-rename packet buffer bus bundle
// Optional outLaneActive_i member exists only with DECBUF_LANE_GATE_EN.
interface decode_pkt_buffer_if #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 32,
    parameter int PKT_BITS  = 64
) ();
    logic [IN_WIDTH-1:0]           inValid_i;
    logic [IN_WIDTH*PKT_BITS-1:0]  inPkt_i;
    logic                          decodeReady_o;
    logic [OUT_WIDTH-1:0]          outValid_o;
    logic [OUT_WIDTH*PKT_BITS-1:0] outPkt_o;
    logic                          renameReady_i;
    logic [$clog2(DEPTH+1)-1:0]    count_o;
`ifdef DECBUF_LANE_GATE_EN
    logic [OUT_WIDTH-1:0]          outLaneActive_i;
`endif

    modport slave (
        input  inValid_i, inPkt_i, renameReady_i,
`ifdef DECBUF_LANE_GATE_EN
        input  outLaneActive_i,
`endif
        output decodeReady_o, outValid_o, outPkt_o, count_o
    );

    modport master (
        output inValid_i, inPkt_i, renameReady_i,
`ifdef DECBUF_LANE_GATE_EN
        output outLaneActive_i,
`endif
        input  decodeReady_o, outValid_o, outPkt_o, count_o
    );
endinterface

// File: rtl/decode_pkt_buffer.sv
// rtl/decode_pkt_buffer.sv - compacting in-order decode-to-rename packet buffer
// Optional output lane gating is enabled by defining DECBUF_LANE_GATE_EN.
module decode_pkt_buffer #(
    parameter int IN_WIDTH  = 8,
    parameter int OUT_WIDTH = 4,
    parameter int DEPTH     = 32,
    parameter int PKT_BITS  = 64
) (
    input logic                 clk,
    input logic                 reset,
    input logic                 flush_i,
    decode_pkt_buffer_if.slave  pkt_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PKT_BITS-1:0] storage_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;

    logic [CNT_W-1:0]    n_in;
    logic [CNT_W-1:0]    n_out;
    logic [CNT_W-1:0]    lane_limit;
    logic [CNT_W-1:0]    avail;
    logic [PTR_W-1:0]    wr_off [IN_WIDTH];
    logic                wr_en;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        n_in = '0;
        for (int k = 0; k < IN_WIDTH; k++) begin
            wr_off[k] = n_in[PTR_W-1:0];
            n_in      = n_in + CNT_W'(pkt_if.inValid_i[k]);
        end
    end

`ifdef DECBUF_LANE_GATE_EN
    always_comb begin
        lane_limit = '0;
        for (int k = 0; k < OUT_WIDTH; k++) begin
            lane_limit = lane_limit + CNT_W'(pkt_if.outLaneActive_i[k]);
        end
    end
`else
    assign lane_limit = CNT_W'(OUT_WIDTH);
`endif

    assign avail = (count_q < lane_limit) ? count_q : lane_limit;

    // Conservative: same-cycle dispatch is not credited toward free space.
    assign wr_en = (count_q <= CNT_W'(DEPTH - IN_WIDTH));

    always_comb begin
        for (int k = 0; k < OUT_WIDTH; k++) begin
            pkt_if.outValid_o[k]                       = (CNT_W'(k) < avail);
            pkt_if.outPkt_o[k*PKT_BITS +: PKT_BITS]    = storage_q[head_q + PTR_W'(k)];
        end
    end

    assign pkt_if.decodeReady_o = wr_en;
    assign pkt_if.count_o       = count_q;

    always_comb begin
        n_out   = pkt_if.renameReady_i ? avail : '0;
        head_d  = head_q + n_out[PTR_W-1:0];
        tail_d  = tail_q + (wr_en ? n_in[PTR_W-1:0] : '0);
        count_d = count_q + (wr_en ? n_in : '0) - n_out;
    end

    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            assert (count_q <= CNT_W'(DEPTH));
        end
    end

    // Storage is deliberately not reset; only occupied entries are ever presented.
    always_ff @(posedge clk) begin
        if (wr_en && !reset && !flush_i) begin
            for (int k = 0; k < IN_WIDTH; k++) begin
                if (pkt_if.inValid_i[k]) begin
                    storage_q[tail_q + wr_off[k]] <= pkt_if.inPkt_i[k*PKT_BITS +: PKT_BITS];
                end
            end
        end
    end
endmodule

// File: tb/tb_decode_pkt_buffer.sv
// tb/tb_decode_pkt_buffer.sv - directed and random checks of decode_pkt_buffer against a queue model
module tb_decode_pkt_buffer;
    localparam int IW = 8;
    localparam int OW = 4;
    localparam int DP = 32;
    localparam int PB = 64;

    logic clk = 1'b0;
    logic reset;
    logic flush_i;

    decode_pkt_buffer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .PKT_BITS(PB)) pkt_if ();

    decode_pkt_buffer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .DEPTH(DP), .PKT_BITS(PB)) dut (
        .clk     (clk),
        .reset   (reset),
        .flush_i (flush_i),
        .pkt_if  (pkt_if.slave)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_errs   = 0;
    logic [63:0]  q [$];
    logic [31:0]  seq = 32'd1;
    logic [OW-1:0] lane_act = '1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lane_lim();
`ifdef DECBUF_LANE_GATE_EN
        return $countones(lane_act);
`else
        return OW;
`endif
    endfunction

    task automatic check_all(input string tag);
        int av;
        av = (q.size() < lane_lim()) ? q.size() : lane_lim();
        chk({tag, "_count"}, 64'(pkt_if.count_o), 64'(q.size()));
        chk({tag, "_ready"}, 64'(pkt_if.decodeReady_o), 64'((DP - q.size()) >= IW));
        chk({tag, "_outvalid"}, 64'(pkt_if.outValid_o), 64'((1 << av) - 1));
        for (int k = 0; k < av; k++)
            chk($sformatf("%s_lane%0d", tag, k), pkt_if.outPkt_o[k*PB +: PB], q[k]);
    endtask

    // Drive one cycle of stimulus, advance the model, then check after the edge.
    task automatic step(input string tag, input logic fl, input logic [IW-1:0] v,
                        input logic rr, input logic lane_idx);
        logic [63:0] vals [IW];
        int nout;
        int lim;
        bit rdy;
        flush_i = fl;
        pkt_if.inValid_i = v;
        pkt_if.renameReady_i = rr;
`ifdef DECBUF_LANE_GATE_EN
        pkt_if.outLaneActive_i = lane_act;
`endif
        for (int k = 0; k < IW; k++) begin
            if (lane_idx) vals[k] = 64'(k);
            else if (v[k]) begin vals[k] = {$urandom, seq}; seq++; end
            else vals[k] = {$urandom, $urandom};
            pkt_if.inPkt_i[k*PB +: PB] = vals[k];
        end
        lim = lane_lim();
        if (fl) begin
            q.delete();
        end else begin
            rdy  = (DP - q.size()) >= IW;
            nout = rr ? ((q.size() < lim) ? q.size() : lim) : 0;
            for (int i = 0; i < nout; i++) void'(q.pop_front());
            if (rdy) for (int k = 0; k < IW; k++) if (v[k]) q.push_back(vals[k]);
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [IW-1:0] rv;
        reset = 1'b1;
        flush_i = 1'b0;
        pkt_if.inValid_i = '0;
        pkt_if.inPkt_i = '0;
        pkt_if.renameReady_i = 1'b0;
`ifdef DECBUF_LANE_GATE_EN
        pkt_if.outLaneActive_i = lane_act;
`endif
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", 64'(pkt_if.count_o), 64'd0);
        chk("rst_outvalid", 64'(pkt_if.outValid_o), 64'd0);
        chk("rst_ready", 64'(pkt_if.decodeReady_o), 64'd1);

        step("sparse", 1'b0, 8'b1010_0101, 1'b0, 1'b1);
        chk("sparse_count", 64'(pkt_if.count_o), 64'd4);
        chk("sparse_ov", 64'(pkt_if.outValid_o), 64'hF);
        chk("sparse_l0", pkt_if.outPkt_o[0*PB +: PB], 64'd0);
        chk("sparse_l1", pkt_if.outPkt_o[1*PB +: PB], 64'd2);
        chk("sparse_l2", pkt_if.outPkt_o[2*PB +: PB], 64'd5);
        chk("sparse_l3", pkt_if.outPkt_o[3*PB +: PB], 64'd7);

        step("fill12", 1'b0, 8'hFF, 1'b0, 1'b0);
        step("fill20", 1'b0, 8'hFF, 1'b0, 1'b0);
        step("fill24", 1'b0, 8'h0F, 1'b0, 1'b0);
        chk("c24_ready", 64'(pkt_if.decodeReady_o), 64'd1);
        step("fill25", 1'b0, 8'h01, 1'b0, 1'b0);
        chk("c25_ready", 64'(pkt_if.decodeReady_o), 64'd0);
        step("blocked", 1'b0, 8'hFF, 1'b0, 1'b0);
        chk("blocked_count", 64'(pkt_if.count_o), 64'd25);
        for (int i = 0; i < 12; i++) step("wrap", 1'b0, 8'hFF, 1'b1, 1'b0);

        step("flush_a", 1'b1, 8'h00, 1'b0, 1'b0);
        step("six", 1'b0, 8'h3F, 1'b0, 1'b0);
        step("simul", 1'b0, 8'hFF, 1'b1, 1'b0);
        chk("simul_count", 64'(pkt_if.count_o), 64'd10);

        step("flush_b", 1'b1, 8'h00, 1'b0, 1'b0);
        step("two", 1'b0, 8'h03, 1'b0, 1'b0);
        chk("two_ov", 64'(pkt_if.outValid_o), 64'h3);
        step("drain2", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("drain2_count", 64'(pkt_if.count_o), 64'd0);
        step("empty_rr", 1'b0, 8'h00, 1'b1, 1'b0);

        step("flush_c", 1'b1, 8'h00, 1'b0, 1'b0);
        step("f8", 1'b0, 8'hFF, 1'b0, 1'b0);
        step("f12", 1'b0, 8'h0F, 1'b0, 1'b0);
        step("flush_wr", 1'b1, 8'hFF, 1'b1, 1'b0);
        chk("flush_count", 64'(pkt_if.count_o), 64'd0);
        chk("flush_ov", 64'(pkt_if.outValid_o), 64'd0);
        chk("flush_ready", 64'(pkt_if.decodeReady_o), 64'd1);
        step("post_flush", 1'b0, 8'h07, 1'b0, 1'b0);

`ifdef DECBUF_LANE_GATE_EN
        step("gate_flush", 1'b1, 8'h00, 1'b0, 1'b0);
        step("gate_six", 1'b0, 8'h3F, 1'b0, 1'b0);
        lane_act = 4'b0011;
        pkt_if.outLaneActive_i = lane_act;
        #1;
        chk("gate_ov", 64'(pkt_if.outValid_o), 64'h3);
        step("gate_rd", 1'b0, 8'h00, 1'b1, 1'b0);
        chk("gate_count", 64'(pkt_if.count_o), 64'd4);
        lane_act = '1;
`endif

        for (int i = 0; i < 400; i++) begin
            rv = IW'($urandom);
            if ($urandom_range(0, 3) == 0) rv = '0;
`ifdef DECBUF_LANE_GATE_EN
            case ($urandom_range(0, 3))
                0: lane_act = 4'b0001;
                1: lane_act = 4'b0011;
                2: lane_act = 4'b0111;
                default: lane_act = 4'b1111;
            endcase
`endif
            step("rand", ($urandom_range(0, 63) == 0), rv, ($urandom_range(0, 1) == 1), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
